// File: rtl/clk_div_scheduler_pkg.sv
// Shared definitions for the clock-divider rate scheduler.
package clk_div_scheduler_pkg;

    // Rate select codes understood by clock_divider
    localparam logic [1:0] RATE_100HZ  = 2'b00;
    localparam logic [1:0] RATE_1KHZ   = 2'b01;
    localparam logic [1:0] RATE_10KHZ  = 2'b10;
    localparam logic [1:0] RATE_100KHZ = 2'b11;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_EDGE,
        APPLY,
        OWNED
    } state_e;

endpackage

// File: rtl/clk_div_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    int unsigned pos;

    // Rotating priority search starting at rr_ptr
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(rr_ptr) + k) % NUM_REQ;
            if (!valid && req[PW'(pos)]) begin
                valid            = 1'b1;
                gnt[PW'(pos)]    = 1'b1;
                idx              = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/clk_div_scheduler.sv
// Round-robin sharing of the clock_divider rate select with glitch-safe switching.
module clk_div_scheduler
    import clk_div_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] rate,
    input  logic                 div_clk,
    output logic [NUM_REQ-1:0]   grant,
    output logic [1:0]           div,
    output logic                 busy,
    output logic                 switch_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    state_e               state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        owner;
    logic [1:0]           target;
    logic [CW-1:0]        cnt;
    logic                 div_clk_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic                 arb_valid;
    logic [1:0]           arb_rate;
    logic [1:0]           owner_rate;
    logic                 owner_req;
    logic                 fall;
    logic [PW-1:0]        next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .valid   (arb_valid)
    );

    assign fall       = div_clk_q & ~div_clk;
    assign arb_rate   = rate[{arb_idx, 1'b0} +: 2];
    assign owner_rate = rate[{owner, 1'b0} +: 2];
    assign owner_req  = req[owner];
    assign next_ptr   = (owner == LAST_IDX) ? '0 : owner + PW'(1);

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            div         <= RATE_100HZ;
            busy        <= 1'b0;
            switch_done <= 1'b0;
            rr_ptr      <= '0;
            owner       <= '0;
            target      <= RATE_100HZ;
            cnt         <= '0;
            div_clk_q   <= 1'b0;
        end else begin
            div_clk_q   <= div_clk;
            switch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) state <= ARB;
                end
                ARB: begin
                    if (!arb_valid) begin
                        state <= IDLE;
                    end else begin
                        grant  <= arb_gnt;
                        owner  <= arb_idx;
                        target <= arb_rate;
                        if (arb_rate == div) begin
                            state <= OWNED;
                        end else begin
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= WAIT_EDGE;
                        end
                    end
                end
                WAIT_EDGE: begin
                    if (!owner_req) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (fall || cnt == CNT_LAST) begin
                        // div and the pulse are registered on entry so both are visible during APPLY
                        div         <= target;
                        switch_done <= 1'b1;
                        busy        <= 1'b0;
                        state       <= APPLY;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                APPLY: begin
                    state <= OWNED;
                end
                OWNED: begin
                    if (!owner_req) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (owner_rate != div) begin
                        target <= owner_rate;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= WAIT_EDGE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Randomized + directed bench for clk_div_scheduler against a transaction-level model.
module tb_clk_div_scheduler;

    localparam int NR = 4;
    localparam int T  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [2*NR-1:0] rate;
    logic            div_clk;
    logic [NR-1:0]   grant;
    logic [1:0]      div;
    logic            busy;
    logic            switch_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // div_clk stimulus: dc_half==0 holds dc_level, otherwise toggles every dc_half cycles
    int   dc_half  = 0;
    logic dc_level = 1'b0;
    int   dc_cnt   = 0;

    clk_div_scheduler #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .rate        (rate),
        .div_clk     (div_clk),
        .grant       (grant),
        .div         (div),
        .busy        (busy),
        .switch_done (switch_done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] rate_of(input logic [2*NR-1:0] r, input int i);
        logic [2*NR-1:0] t;
        t = r >> (2 * i);
        return t[1:0];
    endfunction

    function automatic bit req_of(input logic [NR-1:0] r, input int i);
        logic [NR-1:0] t;
        t = r >> i;
        return t[0];
    endfunction

    // Reference model: ownership, pending switch and apply pulse as plain variables
    int         m_owner = -1;
    bit         m_arb   = 0;
    bit         m_sw    = 0;
    bit         m_apply = 0;
    logic [1:0] m_div   = 2'b00;
    logic [1:0] m_tgt   = 2'b00;
    int         m_ptr   = 0;
    int         m_wait  = 0;
    logic       m_prev  = 1'b0;

    always @(posedge clk) begin
        bit fall;
        int w;
        fall = (m_prev == 1'b1) && (div_clk == 1'b0);
        if (reset) begin
            m_owner = -1; m_arb = 0; m_sw = 0; m_apply = 0;
            m_div = 2'b00; m_ptr = 0; m_wait = 0; m_prev = 1'b0;
        end else begin
            m_prev = div_clk;
            if (m_apply) begin
                m_apply = 0;
            end else if (m_owner < 0 && !m_arb) begin
                m_arb = (req != '0);
            end else if (m_arb) begin
                m_arb = 0;
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && req_of(req, (m_ptr + k) % NR)) w = (m_ptr + k) % NR;
                if (w >= 0) begin
                    m_owner = w;
                    m_tgt = rate_of(rate, w);
                    if (m_tgt != m_div) begin m_sw = 1; m_wait = 0; end
                end
            end else if (!req_of(req, m_owner)) begin
                m_ptr = (m_owner + 1) % NR;
                m_owner = -1;
                m_sw = 0;
            end else if (m_sw) begin
                if (fall || m_wait == T - 1) begin
                    m_sw = 0; m_div = m_tgt; m_apply = 1;
                end else begin
                    m_wait++;
                end
            end else if (rate_of(rate, m_owner) != m_div) begin
                m_tgt = rate_of(rate, m_owner);
                m_sw = 1;
                m_wait = 0;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [NR-1:0] eg;
        if (chk_en) begin
            eg = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
            cmp("grant", 32'(grant), 32'(eg));
            cmp("div", 32'(div), 32'(m_div));
            cmp("busy", 32'(busy), 32'(m_sw));
            cmp("switch_done", 32'(switch_done), 32'(m_apply));
        end
    end

    // div_clk driver, same clock domain
    always @(negedge clk) begin
        if (dc_half == 0) begin
            div_clk = dc_level;
            dc_cnt = 0;
        end else begin
            dc_cnt++;
            if (dc_cnt >= dc_half) begin
                div_clk = ~div_clk;
                dc_cnt = 0;
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input logic [NR-1:0] exp, input int budget, input string nm,
                              output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (grant == exp) break;
        end
        cmp(nm, 32'(grant), 32'(exp));
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c;
        c = 0;
        while (c < budget) begin
            @(negedge clk);
            c++;
            if (switch_done) break;
        end
        cmp(nm, 32'(switch_done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int bc;
        bit seen;
        reset = 1'b1;
        req = '0;
        rate = '0;
        div_clk = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        cmp("rst_grant", 32'(grant), 32'd0);
        cmp("rst_div", 32'(div), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_done", 32'(switch_done), 32'd0);

        // Switch on first grant, released by div_clk fall
        reset_dut();
        dc_half = 3;
        req = 4'b0001;
        rate = 8'h01;
        @(negedge clk);
        cmp("t1_grant_1cyc", 32'(grant), 32'd0);
        @(negedge clk);
        cmp("t1_grant_2cyc", 32'(grant), 32'b0001);
        cmp("t1_busy", 32'(busy), 32'd1);
        wait_done(40, "t1_done");
        cmp("t1_div", 32'(div), 32'b01);
        @(negedge clk);
        cmp("t1_pulse_end", 32'(switch_done), 32'd0);

        // Rate already matches: no switch
        reset_dut();
        req = 4'b0100;
        rate = 8'h00;
        wait_grant(4'b0100, 5, "t2_grant", cyc);
        cmp("t2_latency", 32'(cyc), 32'd2);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || switch_done) seen = 1;
        end
        cmp("t2_no_switch", 32'(seen), 32'd0);

        // Round robin order and pointer wrap
        reset_dut();
        rate = 8'h00;
        req = 4'b1011;
        wait_grant(4'b0001, 5, "t3_g0", cyc);
        req = 4'b1010;
        wait_grant(4'b0010, 6, "t3_g1", cyc);
        cmp("t3_release_lat", 32'(cyc), 32'd3);
        req = 4'b1000;
        wait_grant(4'b1000, 6, "t3_g3", cyc);
        req = 4'b0110;
        wait_grant(4'b0010, 6, "t3_wrap", cyc);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Timeout when div_clk never falls
        reset_dut();
        dc_half = 0;
        dc_level = 1'b0;
        repeat (2) @(negedge clk);
        req = 4'b0001;
        rate = 8'h03;
        wait_grant(4'b0001, 5, "t4_grant", cyc);
        bc = busy ? 1 : 0;
        cyc = 0;
        while (cyc < 100 && !switch_done) begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end
        cmp("t4_busy_cycles", 32'(bc), 32'(T));
        cmp("t4_div", 32'(div), 32'b11);

        // Owner rate changes during ownership; non-owner changes ignored
        dc_half = 2;
        req = 4'b0011;
        rate = 8'b00_00_00_01;
        wait_done(60, "t5_done_01");
        @(negedge clk);
        rate = 8'b00_00_00_10;
        @(negedge clk);
        cmp("t5_busy", 32'(busy), 32'd1);
        wait_done(60, "t5_done_10");
        cmp("t5_div", 32'(div), 32'b10);
        rate = 8'b00_00_11_10;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || switch_done || div != 2'b10) seen = 1;
        end
        cmp("t5_nonowner", 32'(seen), 32'd0);

        // Reset in the middle of a pending switch
        dc_half = 0;
        dc_level = 1'b0;
        repeat (3) @(negedge clk);
        rate = 8'b00_00_11_01;
        repeat (3) @(negedge clk);
        cmp("t6_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        cmp("t6_grant", 32'(grant), 32'd0);
        cmp("t6_div", 32'(div), 32'd0);
        cmp("t6_busy", 32'(busy), 32'd0);
        cmp("t6_done", 32'(switch_done), 32'd0);
        reset = 1'b0;
        req = '0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 150 == 0) begin
                dc_half = $urandom_range(0, 5);
                dc_level = 1'($urandom_range(0, 1));
            end
            for (int b = 0; b < NR; b++)
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 7) == 0) rate = 8'($urandom);
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
